// File: rtl/otter_dcdr_stage.sv
// Registered instruction-decode stage for the pipelined OTTER core (valid/ready in, control word out).
// Define OTTER_DCDR_SKID_EN to add a one-entry skid register so in_ready no longer depends on out_ready.
module otter_dcdr_stage #(
    parameter  int NUM_IRQ = 2,
    localparam int CW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        ir,
    input  logic               flush,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mie,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         alu_fun,
    output logic [1:0]         alu_srcA,
    output logic [2:0]         alu_srcB,
    output logic [1:0]         rf_wr_sel,
    output logic               rf_we,
    output logic [2:0]         pc_src,
    output logic [2:0]         br_fun,
    output logic               int_taken,
    output logic [CW-1:0]      int_cause,
    output logic               illegal
);

    typedef enum logic {
        ST_NORMAL     = 1'b0,
        ST_IN_SERVICE = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0]    alu_fun;
        logic [1:0]    alu_srcA;
        logic [2:0]    alu_srcB;
        logic [1:0]    rf_wr_sel;
        logic          rf_we;
        logic [2:0]    pc_src;
        logic [2:0]    br_fun;
        logic          int_taken;
        logic [CW-1:0] int_cause;
        logic          illegal;
    } ctrl_t;

    localparam ctrl_t IDLE_WORD = '{alu_fun: 4'd0, alu_srcA: 2'd0, alu_srcB: 3'd0,
                                    rf_wr_sel: 2'd3, rf_we: 1'b0, pc_src: 3'd0,
                                    br_fun: 3'd0, int_taken: 1'b0, int_cause: '0,
                                    illegal: 1'b0};

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    logic [2:0]    f3;
    logic          is_mret;
    ctrl_t         dec_word;
    ctrl_t         inj_word;
    ctrl_t         new_word;
    logic [CW-1:0] irq_cause;
    state_e        state_q, state_d;
    logic          irq_pend_q, irq_pend_d;
    logic          irq_allowed;
    logic          accept, take, inject, mret_acc;
    ctrl_t         out_word_q, out_word_d;
    logic          out_valid_q, out_valid_d;
    logic          unused_ir;

    assign f3        = ir[14:12];
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_word       = IDLE_WORD;
        dec_word.rf_we = 1'b1;
        is_mret        = 1'b0;
        case (ir[6:0])
            OP_RTYPE:  dec_word.alu_fun = {ir[30], f3};
            OP_ITYPE: begin
                dec_word.alu_srcB = 3'd1;
                dec_word.alu_fun  = (f3 == 3'b101) ? {ir[30], f3} : {1'b0, f3};
            end
            OP_LOAD: begin
                dec_word.alu_srcB  = 3'd1;
                dec_word.rf_wr_sel = 2'd2;
            end
            OP_JALR: begin
                dec_word.alu_srcB  = 3'd1;
                dec_word.pc_src    = 3'd1;
                dec_word.rf_wr_sel = 2'd0;
            end
            OP_STORE: begin
                dec_word.alu_srcB = 3'd2;
                dec_word.rf_we    = 1'b0;
            end
            OP_BRANCH: begin
                dec_word.pc_src = 3'd2;
                dec_word.br_fun = f3;
                dec_word.rf_we  = 1'b0;
            end
            OP_LUI: begin
                dec_word.alu_fun  = 4'b1001;
                dec_word.alu_srcA = 2'd1;
            end
            OP_AUIPC: begin
                dec_word.alu_srcA = 2'd1;
                dec_word.alu_srcB = 3'd3;
            end
            OP_JAL: begin
                dec_word.pc_src    = 3'd3;
                dec_word.rf_wr_sel = 2'd0;
            end
            OP_SYS: begin
                dec_word.alu_srcB  = 3'd4;
                dec_word.rf_wr_sel = 2'd1;
                case (f3)
                    3'b001: dec_word.alu_fun = 4'b1001;
                    3'b010: dec_word.alu_fun = 4'b0110;
                    3'b011: begin
                        dec_word.alu_fun  = 4'b0111;
                        dec_word.alu_srcA = 2'd2;
                    end
                    3'b000: begin
                        dec_word.pc_src = 3'd5;
                        dec_word.rf_we  = 1'b0;
                        is_mret         = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: begin
                dec_word.illegal = 1'b1;
                dec_word.pc_src  = 3'd4;
                dec_word.rf_we   = 1'b0;
            end
        endcase
    end

    // Lowest-index request wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        irq_cause = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) irq_cause = CW'(i);
        end
    end

    always_comb begin
        inj_word           = IDLE_WORD;
        inj_word.int_taken = 1'b1;
        inj_word.pc_src    = 3'd4;
        inj_word.int_cause = irq_cause;
    end

    assign accept   = in_valid && in_ready;
    assign take     = accept && !flush;
    assign inject   = take && irq_pend_q;
    assign mret_acc = take && !irq_pend_q && is_mret;
    assign new_word = irq_pend_q ? inj_word : dec_word;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_NORMAL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL:     if (inject)   state_d = ST_IN_SERVICE;
            ST_IN_SERVICE: if (mret_acc) state_d = ST_NORMAL;
            default:                     state_d = ST_NORMAL;
        endcase
    end

    always_comb begin
        irq_allowed = (state_q == ST_NORMAL);
    end

    // A flush freezes the pending flag, so an injection lost to a flush is retried.
    always_comb begin
        irq_pend_d = irq_pend_q;
        if (!flush) begin
            if (inject)                          irq_pend_d = 1'b0;
            else if (|irq && mie && irq_allowed) irq_pend_d = 1'b1;
        end
    end

`ifdef OTTER_DCDR_SKID_EN
    ctrl_t skid_word_q, skid_word_d;
    logic  skid_valid_q, skid_valid_d;

    assign in_ready = !skid_valid_q;

    // Skid is only ever filled while the output entry is valid, so promotion keeps out_valid high.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        skid_valid_d = skid_valid_q;
        skid_word_d  = skid_word_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_ready) begin
                out_word_d   = skid_word_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_ready) begin
            out_valid_d = take;
            if (take) out_word_d = new_word;
        end else if (take) begin
            skid_valid_d = 1'b1;
            skid_word_d  = new_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            skid_valid_q <= 1'b0;
            skid_word_q  <= IDLE_WORD;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_word_q  <= skid_word_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (take) begin
            out_valid_d = 1'b1;
            out_word_d  = new_word;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            // NOTE: the payload is reset as well so the idle control word is defined out of reset.
            out_word_q  <= IDLE_WORD;
        end else begin
            irq_pend_q  <= irq_pend_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_fun   = out_word_q.alu_fun;
    assign alu_srcA  = out_word_q.alu_srcA;
    assign alu_srcB  = out_word_q.alu_srcB;
    assign rf_wr_sel = out_word_q.rf_wr_sel;
    assign rf_we     = out_word_q.rf_we;
    assign pc_src    = out_word_q.pc_src;
    assign br_fun    = out_word_q.br_fun;
    assign int_taken = out_word_q.int_taken;
    assign int_cause = out_word_q.int_cause;
    assign illegal   = out_word_q.illegal;

endmodule

// File: tb/tb_otter_dcdr_stage.sv
// Self-checking bench for otter_dcdr_stage: directed scenarios plus a randomized run
// against a queue-based transaction model of the stage.
module tb_otter_dcdr_stage;

`ifdef OTTER_DCDR_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] alu_fun;
        logic [1:0] src_a;
        logic [2:0] src_b;
        logic [1:0] wr_sel;
        logic       we;
        logic [2:0] pc_src;
        logic [2:0] br_fun;
        logic       int_taken;
        logic       int_cause;
        logic       illegal;
    } cw_t;

    localparam logic [31:0] I_ADD  = 32'h00A30333;
    localparam logic [31:0] I_SUB  = 32'h40B50533;
    localparam logic [31:0] I_SRAI = 32'h40535293;
    localparam logic [31:0] I_BEQ  = 32'h00B50463;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] I_MRET = 32'h30200073;
    localparam logic [31:0] I_LUI  = 32'h000012B7;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_ready, flush, mie, out_valid, out_ready;
    logic [31:0] ir;
    logic [1:0]  irq;
    logic [3:0]  alu_fun;
    logic [1:0]  alu_srcA, rf_wr_sel;
    logic [2:0]  alu_srcB, pc_src, br_fun;
    logic        rf_we, int_taken, illegal;
    logic [0:0]  int_cause;

    int total = 0;
    int bad   = 0;

    cw_t q[$];
    bit  m_pend, m_insvc;

    otter_dcdr_stage #(.NUM_IRQ(2)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
        .flush(flush), .irq(irq), .mie(mie), .out_valid(out_valid), .out_ready(out_ready),
        .alu_fun(alu_fun), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .rf_wr_sel(rf_wr_sel),
        .rf_we(rf_we), .pc_src(pc_src), .br_fun(br_fun), .int_taken(int_taken),
        .int_cause(int_cause), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    function automatic cw_t mk(input int alu, input int a, input int b, input int sel,
                               input int we, input int pc, input int br);
        cw_t c;
        c.alu_fun   = 4'(alu);
        c.src_a     = 2'(a);
        c.src_b     = 3'(b);
        c.wr_sel    = 2'(sel);
        c.we        = 1'(we);
        c.pc_src    = 3'(pc);
        c.br_fun    = 3'(br);
        c.int_taken = 1'b0;
        c.int_cause = 1'b0;
        c.illegal   = 1'b0;
        return c;
    endfunction

    function automatic cw_t ref_decode(input logic [31:0] w);
        int  f3;
        cw_t c;
        f3 = int'(w[14:12]);
        case (w[6:0])
            7'b0110011: return mk(int'(w[30]) * 8 + f3, 0, 0, 3, 1, 0, 0);
            7'b0010011: return mk((f3 == 5) ? int'(w[30]) * 8 + f3 : f3, 0, 1, 3, 1, 0, 0);
            7'b0000011: return mk(0, 0, 1, 2, 1, 0, 0);
            7'b1100111: return mk(0, 0, 1, 0, 1, 1, 0);
            7'b0100011: return mk(0, 0, 2, 3, 0, 0, 0);
            7'b1100011: return mk(0, 0, 0, 3, 0, 2, f3);
            7'b0110111: return mk(9, 1, 0, 3, 1, 0, 0);
            7'b0010111: return mk(0, 1, 3, 3, 1, 0, 0);
            7'b1101111: return mk(0, 0, 0, 0, 1, 3, 0);
            7'b1110011: begin
                case (f3)
                    1:       return mk(9, 0, 4, 1, 1, 0, 0);
                    2:       return mk(6, 0, 4, 1, 1, 0, 0);
                    3:       return mk(7, 2, 4, 1, 1, 0, 0);
                    0:       return mk(0, 0, 4, 1, 0, 5, 0);
                    default: return mk(0, 0, 4, 1, 1, 0, 0);
                endcase
            end
            default: begin
                c = mk(0, 0, 0, 3, 0, 4, 0);
                c.illegal = 1'b1;
                return c;
            end
        endcase
    endfunction

    function automatic cw_t ref_inject(input logic [1:0] lines);
        cw_t c;
        c = mk(0, 0, 0, 3, 0, 4, 0);
        c.int_taken = 1'b1;
        c.int_cause = (!lines[0] && lines[1]) ? 1'b1 : 1'b0;
        return c;
    endfunction

    function automatic cw_t dut_word();
        cw_t c;
        c.alu_fun   = alu_fun;
        c.src_a     = alu_srcA;
        c.src_b     = alu_srcB;
        c.wr_sel    = rf_wr_sel;
        c.we        = rf_we;
        c.pc_src    = pc_src;
        c.br_fun    = br_fun;
        c.int_taken = int_taken;
        c.int_cause = int_cause[0];
        c.illegal   = illegal;
        return c;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [13] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                  7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011,
                                  7'b0000000, 7'b1111111, 7'b0001111};
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 12);
        w[6:0] = ops[k];
        if (k == 9 && $urandom_range(0, 1) == 0) w[14:12] = 3'b000;
        return w;
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; in_valid = 1'b0; flush = 1'b0; irq = 2'b00; mie = 1'b0;
        out_ready = 1'b0; ir = 32'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (dut_word() !== mk(0, 0, 0, 3, 0, 0, 0))
            begin bad++; $display("FAIL reset_word got=%h exp=%h", dut_word(), mk(0, 0, 0, 3, 0, 0, 0)); end
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        in_valid = 1'b1; ir = I_ADD; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        total++; if (dut_word() !== mk(0, 0, 0, 3, 1, 0, 0))
            begin bad++; $display("FAIL add_word got=%h exp=%h", dut_word(), mk(0, 0, 0, 3, 1, 0, 0)); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall_srai();
        in_valid = 1'b1; ir = I_SRAI; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (in_ready !== SKID) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=%b", c, in_ready, SKID); end
            total++; if (out_valid !== 1'b1 || alu_fun !== 4'b1101 || alu_srcB !== 3'd1)
                begin bad++; $display("FAIL stall_hold c=%0d got=%b/%b/%0d exp=1/1101/1", c, out_valid, alu_fun, alu_srcB); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_consumed got=%b exp=0", out_valid); end
    endtask

    task automatic test_branch_illegal();
        cw_t e;
        out_ready = 1'b1; in_valid = 1'b1; ir = I_BEQ;
        tick();
        ir = I_BAD;
        total++; if (dut_word() !== mk(0, 0, 0, 3, 0, 2, 0))
            begin bad++; $display("FAIL beq_word got=%h exp=%h", dut_word(), mk(0, 0, 0, 3, 0, 2, 0)); end
        tick();
        in_valid = 1'b0;
        e = mk(0, 0, 0, 3, 0, 4, 0);
        e.illegal = 1'b1;
        total++; if (out_valid !== 1'b1 || dut_word() !== e)
            begin bad++; $display("FAIL illegal_word got=%b/%h exp=1/%h", out_valid, dut_word(), e); end
        tick();
    endtask

    task automatic test_interrupt();
        out_ready = 1'b1; mie = 1'b1; irq = 2'b10; in_valid = 1'b0;
        tick();
        in_valid = 1'b1; ir = I_ADD;
        tick();
        irq = 2'b01;
        total++; if (out_valid !== 1'b1 || int_taken !== 1'b1 || int_cause !== 1'b1 || pc_src !== 3'd4 || rf_we !== 1'b0)
            begin bad++; $display("FAIL irq_inject got=%b/%b/%0d/%0d/%b exp=1/1/1/4/0", out_valid, int_taken, int_cause, pc_src, rf_we); end
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (dut_word() !== mk(0, 0, 0, 3, 1, 0, 0))
                begin bad++; $display("FAIL irq_ignored c=%0d got=%h exp=%h", c, dut_word(), mk(0, 0, 0, 3, 1, 0, 0)); end
        end
        ir = I_MRET;
        tick();
        in_valid = 1'b0;
        total++; if (dut_word() !== mk(0, 0, 4, 1, 0, 5, 0))
            begin bad++; $display("FAIL mret_word got=%h exp=%h", dut_word(), mk(0, 0, 4, 1, 0, 5, 0)); end
        tick();
        irq = 2'b00; in_valid = 1'b1; ir = I_ADD;
        tick();
        in_valid = 1'b0;
        total++; if (int_taken !== 1'b1 || int_cause !== 1'b0)
            begin bad++; $display("FAIL irq_rearm got=%b/%0d exp=1/0", int_taken, int_cause); end
        in_valid = 1'b1; ir = I_MRET;
        tick();
        in_valid = 1'b0; mie = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; ir = I_ADD;
        tick();
        flush = 1'b1; ir = I_LUI;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped c=%0d got=%b exp=0", c, out_valid); end
        end
        mie = 1'b1; irq = 2'b01;
        tick();
        mie = 1'b0; irq = 2'b00; flush = 1'b1; in_valid = 1'b1; ir = I_ADD;
        tick();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_inj_valid got=%b exp=0", out_valid); end
        tick();
        ir = I_MRET;
        total++; if (out_valid !== 1'b1 || int_taken !== 1'b1 || int_cause !== 1'b0)
            begin bad++; $display("FAIL flush_inj_retry got=%b/%b/%0d exp=1/1/0", out_valid, int_taken, int_cause); end
        tick();
        in_valid = 1'b0;
        total++; if (pc_src !== 3'd5) begin bad++; $display("FAIL flush_mret got=%0d exp=5", pc_src); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; ir = I_ADD;
        tick();
        ir = I_SUB;
        #1;
        total++; if (in_ready !== SKID) begin bad++; $display("FAIL b2b_ready1 got=%b exp=%b", in_ready, SKID); end
        tick();
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready2 got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b1 || alu_fun !== 4'b0000)
            begin bad++; $display("FAIL b2b_first got=%b/%b exp=1/0000", out_valid, alu_fun); end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== SKID || (SKID && alu_fun !== 4'b1000))
            begin bad++; $display("FAIL b2b_second got=%b/%b exp=%b/1000", out_valid, alu_fun, SKID); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        bit exp_rdy, acc, set;
        RST = 1'b1; in_valid = 1'b0; flush = 1'b0; irq = 2'b00; mie = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        q.delete(); m_pend = 1'b0; m_insvc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            mie       = 1'($urandom_range(0, 1));
            irq       = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            ir        = rand_instr();
            #1;
            exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, in_ready, exp_rdy); end
            acc = in_valid && exp_rdy;
            set = (|irq) && mie && !m_insvc;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (acc && m_pend) begin
                    q.push_back(ref_inject(irq));
                    m_pend  = 1'b0;
                    m_insvc = 1'b1;
                end else begin
                    if (acc) begin
                        q.push_back(ref_decode(ir));
                        if (ir[6:0] == 7'b1110011 && ir[14:12] == 3'b000) m_insvc = 1'b0;
                    end
                    if (set) m_pend = 1'b1;
                end
            end
            tick();
            total++; if (out_valid !== (q.size() != 0))
                begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                total++; if (dut_word() !== q[0])
                    begin bad++; $display("FAIL rand_word cyc=%0d got=%h exp=%h", i, dut_word(), q[0]); end
            end
        end
        in_valid = 1'b0; flush = 1'b0; irq = 2'b00; mie = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_stall_srai();
        test_branch_illegal();
        test_interrupt();
        test_flush();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
